// File: rtl/spu32_cpu_mulseq_pkg.sv
// Shared definitions for the sequential multiplier: FSM states, ALU opcodes
// and the limb/step-counter sizing helper.
package spu32_cpu_mulseq_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StFix,
    StDone
  } state_e;

  // ALU opcodes that select the multiply sign mode (shared with the ALU decoder).
  localparam logic [3:0] ALUOP_MUL    = 4'b1010;
  localparam logic [3:0] ALUOP_MULH   = 4'b1011;
  localparam logic [3:0] ALUOP_MULHSU = 4'b1100;
  localparam logic [3:0] ALUOP_MULHU  = 4'b1101;

  // Width of the step counter k for N limbs per operand (N*N steps).
  // A single step still needs a 1-bit counter to stay a legal vector.
  function automatic int unsigned k_width(input int unsigned n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

  // Default configuration: 32-bit operands split into 16-bit limbs.
  localparam int unsigned MULSEQ_N_DEFAULT   = 32 / 16;
  localparam int unsigned MULSEQ_K_W_DEFAULT = k_width(MULSEQ_N_DEFAULT);

endpackage

// File: rtl/spu32_cpu_mulseq_pp.sv
// One LIMB x LIMB unsigned partial product, shifted into place and added to
// the accumulator. Purely combinational so the DSP multiply is inferred here.
module spu32_cpu_mulseq_pp #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned LIMB = 16,
  parameter int unsigned PW   = 3
) (
  input  logic [LIMB-1:0]   a_i,
  input  logic [LIMB-1:0]   b_i,
  input  logic [PW-1:0]     pos_i,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [2*LIMB-1:0] a_ext;
  logic [2*LIMB-1:0] b_ext;
  logic [2*XLEN-1:0] prod_ext;

  // Multiply limbs, place the product at limb position pos_i, accumulate.
  always_comb begin
    a_ext    = {{LIMB{1'b0}}, a_i};
    b_ext    = {{LIMB{1'b0}}, b_i};
    prod_ext = '0;
    prod_ext[2*LIMB-1:0] = a_ext * b_ext;
    acc_o    = acc_i + (prod_ext << (LIMB * pos_i));
  end

endmodule

// File: rtl/spu32_cpu_mulseq.sv
// Multi-cycle multiplier for the SPU32 ALU path. Multiplies operand magnitudes
// one limb pair per clock, then applies the sign in a single fix-up cycle.
// Optional build macro SPU32_MUL_EARLYOUT_EN: operands whose magnitudes fit in
// limb 0 finish after a single partial product.
module spu32_cpu_mulseq
  import spu32_cpu_mulseq_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned LIMB = 16
) (
  input  logic              I_clk,
  input  logic              I_reset_n,
  input  logic              I_en,
  input  logic [3:0]        I_op,
  input  logic [XLEN-1:0]   I_s1,
  input  logic [XLEN-1:0]   I_s2,
  output logic [2*XLEN-1:0] O_result,
  output logic              O_busy
);

  localparam int unsigned N     = XLEN / LIMB;
  localparam int unsigned LOG_N = (N > 1) ? $clog2(N) : 0;
  localparam int unsigned K_W   = k_width(N);
  localparam int unsigned PW    = K_W + 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N * N - 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              neg_q, neg_d;
  logic              early_q, early_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] result_q, result_d;

  logic              sgn1, sgn2;
  logic [XLEN-1:0]   mag1, mag2;
  logic [K_W-1:0]    idx_i, idx_j;
  logic [LIMB-1:0]   a_limb, b_limb;
  logic [PW-1:0]     pos;
  logic [2*XLEN-1:0] acc_sum;

  // Operand sign decode and magnitudes; the most negative value maps to itself.
  always_comb begin
    sgn1 = ((I_op == ALUOP_MULH) || (I_op == ALUOP_MULHSU)) && I_s1[XLEN-1];
    sgn2 = (I_op == ALUOP_MULH) && I_s2[XLEN-1];
    mag1 = sgn1 ? -I_s1 : I_s1;
    mag2 = sgn2 ? -I_s2 : I_s2;
`ifdef SPU32_MUL_EARLYOUT_EN
    early_d = ((mag1 >> LIMB) == '0) && ((mag2 >> LIMB) == '0);
`else
    early_d = 1'b0;
`endif
  end

  // Limb selection for step k: i = k / N, j = k % N.
  always_comb begin
    idx_i  = k_q >> LOG_N;
    idx_j  = k_q & K_W'(N - 1);
    a_limb = LIMB'(a_q >> (LIMB * idx_i));
    b_limb = LIMB'(b_q >> (LIMB * idx_j));
    pos    = {1'b0, idx_i} + {1'b0, idx_j};
  end

  spu32_cpu_mulseq_pp #(
    .XLEN (XLEN),
    .LIMB (LIMB),
    .PW   (PW)
  ) u_pp (
    .a_i   (a_limb),
    .b_i   (b_limb),
    .pos_i (pos),
    .acc_i (acc_q),
    .acc_o (acc_sum)
  );

  // Next-state and busy decode.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_d    = neg_q;
    k_d      = k_q;
    acc_d    = acc_q;
    result_d = result_q;
    O_busy   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Gated by reset so busy reads low throughout reset.
        O_busy = I_en & I_reset_n;
        if (I_en) begin
          a_d     = mag1;
          b_d     = mag2;
          neg_d   = sgn1 ^ sgn2;
          acc_d   = '0;
          k_d     = '0;
          state_d = StMul;
        end
      end
      StMul: begin
        O_busy = 1'b1;
        acc_d  = acc_sum;
        k_d    = k_q + 1'b1;
        if ((k_q == K_LAST) || early_q) begin
          state_d = StFix;
        end
      end
      StFix: begin
        O_busy   = 1'b1;
        result_d = neg_q ? -acc_q : acc_q;
        state_d  = StDone;
      end
      StDone: begin
        // Require I_en to drop before a new request is taken.
        if (!I_en) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Early-out decision is captured together with the operands at acceptance.
  logic early_en;
  assign early_en = (state_q == StIdle) && I_en;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      early_q  <= 1'b0;
      k_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      if (early_en) begin
        early_q <= early_d;
      end
    end
  end

  assign O_result = result_q;

endmodule

// File: tb/tb_spu32_cpu_mulseq.sv
// Directed bench for the sequential multiplier: table of sign-mode vectors
// with latency and product checks, plus reset-abort and hold-in-DONE sequences.
module tb_spu32_cpu_mulseq;
  import spu32_cpu_mulseq_pkg::*;

`ifdef SPU32_MUL_EARLYOUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif
  localparam int FullLat = 6;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  op;
  logic [31:0] s1;
  logic [31:0] s2;
  logic [63:0] result;
  logic        busy;

  int n_cmp;
  int n_fail;

  spu32_cpu_mulseq #(
    .XLEN (32),
    .LIMB (16)
  ) dut (
    .I_clk     (clk),
    .I_reset_n (rst_n),
    .I_en      (en),
    .I_op      (op),
    .I_s1      (s1),
    .I_s2      (s2),
    .O_result  (result),
    .O_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [63:0] exp;
    int          lat_eo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Issue one request, measure busy cycles, check product. Optionally change the
  // operands mid-operation and keep I_en high in DONE for a few cycles.
  task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat,
                        input bit scramble);
    int lat;
    @(posedge clk);
    #1;
    en  = 1'b1;
    op  = o;
    s1  = a;
    s2  = b;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (scramble && c == 1) begin
        op = ALUOP_MULH;
        s1 = 32'hFFFF_FFFF;
        s2 = 32'h8000_0000;
      end
      if (!busy) begin
        lat = c;
        break;
      end
    end
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    check({name, " result"}, result, exp);
    if (scramble) begin
      for (int h = 0; h < 3; h++) begin
        @(negedge clk);
        check({name, " hold busy"}, {63'd0, busy}, 64'd0);
        check({name, " hold result"}, result, exp);
      end
    end
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    en     = 1'b0;
    op     = 4'd0;
    s1     = '0;
    s2     = '0;

    vecs[0]  = '{ALUOP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 3};
    vecs[1]  = '{ALUOP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 6};
    vecs[2]  = '{ALUOP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 6};
    vecs[3]  = '{ALUOP_MULH,   32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 6};
    vecs[4]  = '{ALUOP_MUL,    32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 6};
    vecs[5]  = '{ALUOP_MUL,    32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 3};
    vecs[6]  = '{ALUOP_MUL,    32'h0000_0003, 32'h0001_0000, 64'h0000_0000_0003_0000, 6};
    vecs[7]  = '{ALUOP_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 3};
    vecs[8]  = '{ALUOP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000_8000_0000, 6};
    vecs[9]  = '{ALUOP_MULH,   32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 6};
    vecs[10] = '{4'd0,         32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 6};
    vecs[11] = '{ALUOP_MULH,   32'h0000_0000, 32'hFFFF_FFFF, 64'h0000_0000_0000_0000, 3};

    // Reset state, including busy suppressed while a request is pending.
    #12;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset result", result, 64'd0);
    en = 1'b1;
    #1;
    check("reset busy with en", {63'd0, busy}, 64'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle busy", {63'd0, busy}, 64'd0);

    for (int v = 0; v < 12; v++) begin
      run_op($sformatf("vec%0d", v), vecs[v].op, vecs[v].s1, vecs[v].s2, vecs[v].exp,
             EarlyOut ? vecs[v].lat_eo : FullLat, 1'b0);
    end

    // Reset asserted in cycle 3 of a MULHU 7x9 aborts it at once.
    @(posedge clk);
    #1;
    en = 1'b1;
    op = ALUOP_MULHU;
    s1 = 32'd7;
    s2 = 32'd9;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy", {63'd0, busy}, 64'd0);
    check("abort result", result, 64'd0);
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;

    // Fresh request after abort; operands change mid-op and I_en stays high in DONE.
    run_op("after abort", ALUOP_MULHU, 32'd7, 32'd9, 64'h3F, EarlyOut ? 3 : FullLat, 1'b1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
